// File: rtl/eth_tx_scheduler_if.sv
// Frame-level control bundle between the TX scheduler and the byte-wide TX stages.
// Handshake: every *_tx_start pulse (or header-type level) from the scheduler launches one
// stage; that stage answers with exactly one *_tx_done pulse when its last byte has gone out.
interface eth_tx_scheduler_if;
  logic        arp_req;
  logic        arp_oper_in;
  logic        ip_req;
  logic [15:0] ip_len;
  logic        arp_grant;
  logic        ip_grant;
  logic        preamble_sfd_tx_start;
  logic        preamble_sfd_tx_done;
  logic        eth_header_arp_tx_start;
  logic        eth_header_ip_tx_start;
  logic        arp_oper;
  logic        eth_header_arp_tx_done;
  logic        eth_header_ip_tx_done;
  logic        payload_tx_start;
  logic [15:0] payload_len;
  logic [5:0]  pad_len;
  logic        payload_tx_done;
  logic        fcs_tx_start;
  logic        fcs_tx_done;
  logic [2:0]  tx_sel;
  logic        busy;

  modport master (
    input  arp_req, arp_oper_in, ip_req, ip_len,
    input  preamble_sfd_tx_done, eth_header_arp_tx_done, eth_header_ip_tx_done,
    input  payload_tx_done, fcs_tx_done,
    output arp_grant, ip_grant, preamble_sfd_tx_start,
    output eth_header_arp_tx_start, eth_header_ip_tx_start, arp_oper,
    output payload_tx_start, payload_len, pad_len, fcs_tx_start, tx_sel, busy
  );

  modport slave (
    output arp_req, arp_oper_in, ip_req, ip_len,
    output preamble_sfd_tx_done, eth_header_arp_tx_done, eth_header_ip_tx_done,
    output payload_tx_done, fcs_tx_done,
    input  arp_grant, ip_grant, preamble_sfd_tx_start,
    input  eth_header_arp_tx_start, eth_header_ip_tx_start, arp_oper,
    input  payload_tx_start, payload_len, pad_len, fcs_tx_start, tx_sel, busy
  );
endinterface

// File: rtl/eth_tx_scheduler.sv
// Ethernet TX frame sequencer: arbitrates ARP/IP requesters and steps preamble, header,
// payload, FCS and inter-frame gap. Define TX_SCHED_RR_EN for round-robin arbitration.
module eth_tx_scheduler #(
  parameter int IFG_BYTES         = 12,
  parameter int ARP_PAYLOAD_BYTES = 28,
  parameter int MIN_PAYLOAD_BYTES = 46
) (
  input  logic                aclk,
  input  logic                aresetn,
  eth_tx_scheduler_if.master  bus,
  output logic [2:0]          state_dbg
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_HEADER   = 3'd2;
  localparam logic [2:0] S_PAYLOAD  = 3'd3;
  localparam logic [2:0] S_FCS      = 3'd4;
  localparam logic [2:0] S_IFG      = 3'd5;

  localparam logic [15:0] ARP_LEN  = 16'(ARP_PAYLOAD_BYTES);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD_BYTES);
  localparam logic [7:0]  IFG_LOAD = 8'(IFG_BYTES - 1);

  logic [2:0]  state;
  logic [7:0]  ifg_cnt;
  logic        pick_arp;
  logic        pick_ip;
  logic [15:0] sel_len;
  logic [5:0]  sel_pad;

`ifdef TX_SCHED_RR_EN
  // 1 = ARP was granted last; only consulted when both requesters are waiting.
  logic last_served;

  always_comb begin
    pick_arp = bus.arp_req & (~bus.ip_req | ~last_served);
    pick_ip  = bus.ip_req & ~pick_arp;
  end
`else
  always_comb begin
    pick_arp = bus.arp_req;
    pick_ip  = bus.ip_req & ~bus.arp_req;
  end
`endif

  always_comb begin
    sel_len = pick_arp ? ARP_LEN : bus.ip_len;
    sel_pad = (sel_len < MIN_LEN) ? 6'(MIN_LEN - sel_len) : 6'd0;
  end

  assign bus.busy  = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                       <= S_IDLE;
      ifg_cnt                     <= '0;
      bus.arp_grant               <= 1'b0;
      bus.ip_grant                <= 1'b0;
      bus.preamble_sfd_tx_start   <= 1'b0;
      bus.eth_header_arp_tx_start <= 1'b0;
      bus.eth_header_ip_tx_start  <= 1'b0;
      bus.arp_oper                <= 1'b0;
      bus.payload_tx_start        <= 1'b0;
      bus.payload_len             <= '0;
      bus.pad_len                 <= '0;
      bus.fcs_tx_start            <= 1'b0;
      bus.tx_sel                  <= 3'd0;
`ifdef TX_SCHED_RR_EN
      last_served                 <= 1'b0;
`endif
    end else begin
      bus.arp_grant             <= 1'b0;
      bus.ip_grant              <= 1'b0;
      bus.preamble_sfd_tx_start <= 1'b0;
      bus.payload_tx_start      <= 1'b0;
      bus.fcs_tx_start          <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pick_arp || pick_ip) begin
            bus.arp_grant               <= pick_arp;
            bus.ip_grant                <= pick_ip;
            bus.preamble_sfd_tx_start   <= 1'b1;
            bus.eth_header_arp_tx_start <= pick_arp;
            bus.eth_header_ip_tx_start  <= pick_ip;
            bus.arp_oper                <= pick_arp & bus.arp_oper_in;
            bus.payload_len             <= sel_len;
            bus.pad_len                 <= sel_pad;
            bus.tx_sel                  <= 3'd1;
            state                       <= S_PREAMBLE;
`ifdef TX_SCHED_RR_EN
            last_served                 <= pick_arp;
`endif
          end
        end
        S_PREAMBLE: begin
          if (bus.preamble_sfd_tx_done) begin
            bus.tx_sel <= 3'd2;
            state      <= S_HEADER;
          end
        end
        S_HEADER: begin
          // A done from the header type not in flight is a stray pulse and is dropped.
          if ((bus.eth_header_arp_tx_start && bus.eth_header_arp_tx_done) ||
              (bus.eth_header_ip_tx_start  && bus.eth_header_ip_tx_done)) begin
            bus.eth_header_arp_tx_start <= 1'b0;
            bus.eth_header_ip_tx_start  <= 1'b0;
            bus.payload_tx_start        <= 1'b1;
            bus.tx_sel                  <= 3'd3;
            state                       <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (bus.payload_tx_done) begin
            bus.fcs_tx_start <= 1'b1;
            bus.tx_sel       <= 3'd4;
            state            <= S_FCS;
          end
        end
        S_FCS: begin
          if (bus.fcs_tx_done) begin
            bus.tx_sel   <= 3'd0;
            bus.arp_oper <= 1'b0;
            ifg_cnt      <= IFG_LOAD;
            state        <= S_IFG;
          end
        end
        S_IFG: begin
          if (ifg_cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt - 8'd1;
          end
        end
        default: begin
          bus.tx_sel <= 3'd0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler: reset, ARP/IP frames, stray dones, padding,
// back-to-back IFG spacing and mid-frame asynchronous reset.
module tb_eth_tx_scheduler;

  logic       aclk;
  logic       aresetn;
  logic [2:0] state_dbg;
  int         checks;
  int         errors;

  eth_tx_scheduler_if bus ();

  eth_tx_scheduler dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // which: 0 preamble, 1 arp header, 2 ip header, 3 payload, 4 fcs
  task automatic pulse(input int which);
    case (which)
      0: bus.preamble_sfd_tx_done   = 1'b1;
      1: bus.eth_header_arp_tx_done = 1'b1;
      2: bus.eth_header_ip_tx_done  = 1'b1;
      3: bus.payload_tx_done        = 1'b1;
      default: bus.fcs_tx_done      = 1'b1;
    endcase
    tick();
    bus.preamble_sfd_tx_done   = 1'b0;
    bus.eth_header_arp_tx_done = 1'b0;
    bus.eth_header_ip_tx_done  = 1'b0;
    bus.payload_tx_done        = 1'b0;
    bus.fcs_tx_done            = 1'b0;
  endtask

  task automatic finish_frame(input bit is_arp);
    pulse(0);
    pulse(is_arp ? 1 : 2);
    pulse(3);
    pulse(4);
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    ok = (bus.busy === 1'b0);
  endtask

  task automatic test_reset();
    bit ok;
    aresetn = 1'b0;
    bus.arp_req = 0; bus.arp_oper_in = 0; bus.ip_req = 0; bus.ip_len = '0;
    bus.preamble_sfd_tx_done = 0; bus.eth_header_arp_tx_done = 0;
    bus.eth_header_ip_tx_done = 0; bus.payload_tx_done = 0; bus.fcs_tx_done = 0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
    ok = (bus.arp_grant === 0) && (bus.ip_grant === 0) && (bus.preamble_sfd_tx_start === 0) &&
         (bus.eth_header_arp_tx_start === 0) && (bus.eth_header_ip_tx_start === 0) &&
         (bus.arp_oper === 0) && (bus.payload_tx_start === 0) && (bus.fcs_tx_start === 0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_pulses: some output nonzero, got %b%b%b%b%b%b%b%b expected all 0",
               bus.arp_grant, bus.ip_grant, bus.preamble_sfd_tx_start, bus.eth_header_arp_tx_start,
               bus.eth_header_ip_tx_start, bus.arp_oper, bus.payload_tx_start, bus.fcs_tx_start);
    end
    checks++;
    if (bus.payload_len !== 16'd0 || bus.pad_len !== 6'd0 || bus.tx_sel !== 3'd0 ||
        bus.busy !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: got len=%0d pad=%0d sel=%0d busy=%0d state=%0d expected all 0",
               bus.payload_len, bus.pad_len, bus.tx_sel, bus.busy, state_dbg);
    end
  endtask

  task automatic test_arp_frame();
    bit ok;
    bus.arp_req = 1'b1;
    bus.arp_oper_in = 1'b1;
    tick();
    bus.arp_req = 1'b0;
    bus.arp_oper_in = 1'b0;
    checks++;
    if (bus.arp_grant !== 1'b1 || bus.ip_grant !== 1'b0 || bus.preamble_sfd_tx_start !== 1'b1 ||
        bus.eth_header_arp_tx_start !== 1'b1 || bus.eth_header_ip_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL arp_grant: got grant=%0d/%0d pre=%0d hdr=%0d/%0d expected 1/0 1 1/0",
               bus.arp_grant, bus.ip_grant, bus.preamble_sfd_tx_start,
               bus.eth_header_arp_tx_start, bus.eth_header_ip_tx_start);
    end
    checks++;
    if (bus.arp_oper !== 1'b1 || bus.payload_len !== 16'd28 || bus.pad_len !== 6'd18 ||
        bus.tx_sel !== 3'd1) begin
      errors++;
      $display("FAIL arp_fields: got oper=%0d len=%0d pad=%0d sel=%0d expected 1 28 18 1",
               bus.arp_oper, bus.payload_len, bus.pad_len, bus.tx_sel);
    end
    tick();
    checks++;
    if (bus.arp_grant !== 1'b0 || bus.preamble_sfd_tx_start !== 1'b0 || bus.arp_oper !== 1'b1) begin
      errors++;
      $display("FAIL arp_hold: got grant=%0d pre=%0d oper=%0d expected 0 0 1",
               bus.arp_grant, bus.preamble_sfd_tx_start, bus.arp_oper);
    end
    pulse(0);
    checks++;
    if (bus.tx_sel !== 3'd2 || bus.eth_header_arp_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL arp_preamble_done: got sel=%0d hdr=%0d expected 2 1", bus.tx_sel,
               bus.eth_header_arp_tx_start);
    end
    pulse(1);
    checks++;
    if (bus.tx_sel !== 3'd3 || bus.payload_tx_start !== 1'b1 || bus.eth_header_arp_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL arp_header_done: got sel=%0d pstart=%0d hdr=%0d expected 3 1 0",
               bus.tx_sel, bus.payload_tx_start, bus.eth_header_arp_tx_start);
    end
    pulse(3);
    checks++;
    if (bus.tx_sel !== 3'd4 || bus.fcs_tx_start !== 1'b1 || bus.payload_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL arp_payload_done: got sel=%0d fstart=%0d pstart=%0d expected 4 1 0",
               bus.tx_sel, bus.fcs_tx_start, bus.payload_tx_start);
    end
    pulse(4);
    checks++;
    if (bus.tx_sel !== 3'd0 || bus.arp_oper !== 1'b0 || bus.busy !== 1'b1 || state_dbg !== 3'd5) begin
      errors++;
      $display("FAIL arp_fcs_done: got sel=%0d oper=%0d busy=%0d state=%0d expected 0 0 1 5",
               bus.tx_sel, bus.arp_oper, bus.busy, state_dbg);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL arp_idle_timeout: got busy=%0d expected 0", bus.busy);
    end
  endtask

  task automatic test_ip_frame_stray_done();
    bit ok;
    bus.ip_req = 1'b1;
    bus.ip_len = 16'd1500;
    tick();
    bus.ip_req = 1'b0;
    bus.ip_len = 16'd7;
    checks++;
    if (bus.ip_grant !== 1'b1 || bus.arp_grant !== 1'b0 || bus.eth_header_ip_tx_start !== 1'b1 ||
        bus.eth_header_arp_tx_start !== 1'b0 || bus.arp_oper !== 1'b0) begin
      errors++;
      $display("FAIL ip_grant: got grant=%0d/%0d hdr=%0d/%0d oper=%0d expected 1/0 1/0 0",
               bus.ip_grant, bus.arp_grant, bus.eth_header_ip_tx_start,
               bus.eth_header_arp_tx_start, bus.arp_oper);
    end
    checks++;
    if (bus.payload_len !== 16'd1500 || bus.pad_len !== 6'd0) begin
      errors++;
      $display("FAIL ip_len_1500: got len=%0d pad=%0d expected 1500 0", bus.payload_len, bus.pad_len);
    end
    pulse(3);
    checks++;
    if (bus.tx_sel !== 3'd1 || state_dbg !== 3'd1 || bus.fcs_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL stray_payload_done: got sel=%0d state=%0d fstart=%0d expected 1 1 0",
               bus.tx_sel, state_dbg, bus.fcs_tx_start);
    end
    pulse(0);
    pulse(1);
    tick();
    checks++;
    if (bus.tx_sel !== 3'd2 || state_dbg !== 3'd2 || bus.payload_tx_start !== 1'b0 ||
        bus.eth_header_ip_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL stray_arp_header_done: got sel=%0d state=%0d pstart=%0d hdr=%0d expected 2 2 0 1",
               bus.tx_sel, state_dbg, bus.payload_tx_start, bus.eth_header_ip_tx_start);
    end
    pulse(2);
    checks++;
    if (bus.tx_sel !== 3'd3 || bus.payload_tx_start !== 1'b1 || bus.eth_header_ip_tx_start !== 1'b0 ||
        bus.payload_len !== 16'd1500) begin
      errors++;
      $display("FAIL ip_header_done: got sel=%0d pstart=%0d hdr=%0d len=%0d expected 3 1 0 1500",
               bus.tx_sel, bus.payload_tx_start, bus.eth_header_ip_tx_start, bus.payload_len);
    end
    pulse(3);
    pulse(4);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ip_idle_timeout: got busy=%0d expected 0", bus.busy);
    end
  endtask

  task automatic test_pad_len();
    logic [15:0] lens [4];
    logic [5:0]  pads [4];
    bit ok;
    lens = '{16'd10, 16'd46, 16'd0, 16'd45};
    pads = '{6'd36, 6'd0, 6'd46, 6'd1};
    for (int i = 0; i < 4; i++) begin
      bus.ip_req = 1'b1;
      bus.ip_len = lens[i];
      tick();
      bus.ip_req = 1'b0;
      bus.ip_len = 16'd999;
      tick();
      checks++;
      if (bus.payload_len !== lens[i] || bus.pad_len !== pads[i]) begin
        errors++;
        $display("FAIL pad_len_%0d: got len=%0d pad=%0d expected %0d %0d",
                 i, bus.payload_len, bus.pad_len, lens[i], pads[i]);
      end
      finish_frame(1'b0);
      wait_idle(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pad_idle_timeout_%0d: got busy=%0d expected 0", i, bus.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_arp [3];
    bit ok;
    int n;
    int gap;
`ifdef TX_SCHED_RR_EN
    exp_arp = '{1'b1, 1'b0, 1'b1};
`else
    exp_arp = '{1'b1, 1'b1, 1'b1};
`endif
    bus.arp_req = 1'b1;
    bus.ip_req = 1'b1;
    bus.arp_oper_in = 1'b0;
    bus.ip_len = 16'd64;
    tick();
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (bus.arp_grant !== exp_arp[f] || bus.ip_grant !== !exp_arp[f]) begin
        errors++;
        $display("FAIL b2b_grant_%0d: got arp=%0d ip=%0d expected arp=%0d ip=%0d",
                 f, bus.arp_grant, bus.ip_grant, exp_arp[f], !exp_arp[f]);
      end
      finish_frame(exp_arp[f]);
      if (f == 2) begin
        bus.arp_req = 1'b0;
        bus.ip_req = 1'b0;
      end else begin
        n = 0;
        gap = 0;
        while (bus.arp_grant !== 1'b1 && bus.ip_grant !== 1'b1 && n < 40) begin
          if (bus.busy === 1'b1 && bus.tx_sel === 3'd0) gap++;
          tick();
          n++;
        end
        checks++;
        if (gap != 12 || n != 13) begin
          errors++;
          $display("FAIL b2b_ifg_%0d: got ifg_cycles=%0d grant_after=%0d expected 12 13", f, gap, n);
        end
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_idle_timeout: got busy=%0d expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bus.ip_req = 1'b1;
    bus.ip_len = 16'd100;
    tick();
    bus.ip_req = 1'b0;
    pulse(0);
    pulse(2);
    checks++;
    if (state_dbg !== 3'd3 || bus.tx_sel !== 3'd3) begin
      errors++;
      $display("FAIL mid_reset_setup: got state=%0d sel=%0d expected 3 3", state_dbg, bus.tx_sel);
    end
    #2;
    aresetn = 1'b0;
    bus.ip_req = 1'b1;
    #1;
    checks++;
    if (bus.tx_sel !== 3'd0 || bus.busy !== 1'b0 || state_dbg !== 3'd0 || bus.payload_len !== 16'd0 ||
        bus.eth_header_ip_tx_start !== 1'b0 || bus.pad_len !== 6'd0 || bus.payload_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got sel=%0d busy=%0d state=%0d len=%0d hdr=%0d pad=%0d pstart=%0d expected all 0",
               bus.tx_sel, bus.busy, state_dbg, bus.payload_len, bus.eth_header_ip_tx_start,
               bus.pad_len, bus.payload_tx_start);
    end
    tick();
    aresetn = 1'b1;
    tick();
    bus.ip_req = 1'b0;
    checks++;
    if (bus.ip_grant !== 1'b1 || bus.tx_sel !== 3'd1 || bus.payload_len !== 16'd100 || bus.pad_len !== 6'd0) begin
      errors++;
      $display("FAIL post_reset_grant: got grant=%0d sel=%0d len=%0d pad=%0d expected 1 1 100 0",
               bus.ip_grant, bus.tx_sel, bus.payload_len, bus.pad_len);
    end
    finish_frame(1'b0);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_reset_idle_timeout: got busy=%0d expected 0", bus.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arp_frame();
    test_ip_frame_stray_done();
    test_pad_len();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000ns");
    $fatal(1);
  end

endmodule
